alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
Parametrised, registered successor to the team's 8-bit combinational ALU. It adds a valid/ready handshake on both input and output, status flags, shift and compare operations, and an iterative shift-add multiply. It sits between an operand-issuing controller and a result consumer. Results are held stable under backpressure.

Parameters:
WIDTH, 8, operand/result width; power of two, at least 4.
SHW, $clog2(WIDTH), shift-amount width; derived, not overridden.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  operands/opcode valid
in_ready  out  1  block can accept an operation
a  in  WIDTH  operand a
b  in  WIDTH  operand b
op  in  4  opcode
out_valid  out  1  result/flags valid
out_ready  in  1  consumer accepts result
z  out  WIDTH  result
flag_zero  out  1  z == 0
flag_neg  out  1  z[WIDTH-1]
flag_carry  out  1  carry/borrow/shift-out/mul-overflow
flag_ovf  out  1  signed overflow (add/sub only)
flag_err  out  1  reserved opcode executed

Behaviour:
- Reset (async, rst=1): state=IDLE; z=0; all flags=0; out_valid=0; multiply datapath cleared. An in-flight operation is discarded and no result is emitted.
- States: IDLE, BUSY (multiply only), DONE.
- in_ready = (state==IDLE) | (state==DONE & out_ready). This is a combinational path from out_ready.
- Accept occurs on a clock edge with in_valid & in_ready. a, b and op are captured at that edge; later changes to the inputs do not affect the operation.
- Single-cycle ops go to DONE at the accept edge, so out_valid=1 one cycle after acceptance.
- op=11 goes to BUSY and runs for WIDTH cycles, one multiplier bit per cycle, then DONE. out_valid rises WIDTH+1 edges after acceptance.
- DONE: z and flags are held constant while out_ready=0.
  - out_ready=1 with no new accept: go to IDLE, out_valid=0 the next cycle.
  - out_ready=1 with a simultaneous accept: start the new op immediately. Back-to-back single-cycle ops give one result per cycle.
- in_valid while BUSY is ignored (in_ready=0). Nothing is queued.
- Opcodes (mod-2^WIDTH arithmetic):
  - 0: clear, z=0
  - 1: z=b-a
  - 2: z=a-b
  - 3: z=a+b
  - 4: a^b
  - 5: a|b
  - 6: a&b
  - 7: preset, all ones
  - 8: z = a << b[SHW-1:0]
  - 9: z = a >> (logical)
  - 10: z = a >>> (arithmetic)
  - 11: z = low WIDTH bits of unsigned a*b
  - 12: z = (a<b unsigned) ? 1 : 0
  - 13-15: reserved; z=0, flag_err=1
- flag_carry:
  - add: carry out.
  - sub: borrow, 1 when minuend < subtrahend (unsigned).
  - shifts: last bit shifted out; 0 when shift amount is 0.
  - mul: 1 when the upper WIDTH bits of the full product are nonzero.
  - all other ops: 0.
- flag_ovf: signed overflow for ops 1-3 only; 0 for all other ops.
- flag_zero and flag_neg are derived from the registered z for every op.
- flag_err is 0 for every op except 13-15.
- Shift amount uses only b[SHW-1:0]; upper bits of b are ignored.

Test Plan:
- WIDTH=8. Assert rst mid-multiply (cycle 3 of BUSY) -> z=0, flags=0, out_valid=0 immediately. After release, in_ready=1 and no stale result appears.
- op=3, a=0x7F, b=0x01 -> one cycle later out_valid=1, z=0x80, neg=1, ovf=1, carry=0, zero=0.
- op=2, a=0x05, b=0x07 -> z=0xFE, carry=1, neg=1. Same operands with op=1 -> z=0x02, carry=0.
- op=10, a=0x90, b=0x05 -> z=0xFC, carry=1. op=8, a=0x81, b=0x09 (amount 1) -> z=0x02, carry=1.
- op=11, a=13, b=11 -> out_valid exactly 9 edges after accept, z=0x8F, carry=0. op=11, a=200, b=3 -> z=0x58, carry=1.
- Hold out_ready=0 for 5 cycles after a result -> z and flags stable, in_ready=0. Then out_ready=1 with a queued in_valid op=4 -> new result the next cycle with no idle bubble. op=14 -> z=0, err=1.

Source files
------------

// File: rtl/alu_seq.sv
// Registered ALU with valid/ready on both sides, status flags, shifts, compare
// and an iterative shift-add multiply. Results hold steady under backpressure.
module alu_seq #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z,
    output logic             flag_zero,
    output logic             flag_neg,
    output logic             flag_carry,
    output logic             flag_ovf,
    output logic             flag_err
);
    localparam int SHW = $clog2(WIDTH);
    localparam int MSB = WIDTH - 1;
    localparam logic [3:0] OP_MUL = 4'd11;

    // Handshake: an operation transfers on a rising edge with in_valid & in_ready;
    // a result transfers on a rising edge with out_valid & out_ready.
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t state, state_next;

    logic             accept, start_mul, mul_last;
    logic [2*WIDTH-1:0] mul_a, acc, acc_next;
    logic [WIDTH-1:0] mul_b;
    logic [SHW-1:0]   mul_cnt;

    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_e;
    logic [WIDTH:0]   sum, diff_ab, diff_ba, shl, shr_l, shr_a;
    logic [SHW-1:0]   sh;

    assign in_ready  = (state == IDLE) | ((state == DONE) & out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid & in_ready;
    assign start_mul = accept & (op == OP_MUL);
    assign mul_last  = (state == BUSY) & (mul_cnt == SHW'(WIDTH - 1));
    assign acc_next  = mul_b[0] ? acc + mul_a : acc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = start_mul ? BUSY : DONE;
            BUSY: if (mul_last) state_next = DONE;
            DONE: begin
                if (accept)         state_next = start_mul ? BUSY : DONE;
                else if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Extra bit on each shift operand catches the last bit shifted out.
    assign sh      = b[SHW-1:0];
    assign sum     = {1'b0, a} + {1'b0, b};
    assign diff_ab = {1'b0, a} - {1'b0, b};
    assign diff_ba = {1'b0, b} - {1'b0, a};
    assign shl     = {1'b0, a} << sh;
    assign shr_l   = {a, 1'b0} >> sh;
    assign shr_a   = $unsigned($signed({a, 1'b0}) >>> sh);

    always_comb begin
        res   = '0;
        res_c = 1'b0;
        res_v = 1'b0;
        res_e = 1'b0;
        case (op)
            4'd0: res = '0;
            4'd1: begin
                res   = diff_ba[MSB:0];
                res_c = diff_ba[WIDTH];
                res_v = (b[MSB] != a[MSB]) & (res[MSB] != b[MSB]);
            end
            4'd2: begin
                res   = diff_ab[MSB:0];
                res_c = diff_ab[WIDTH];
                res_v = (a[MSB] != b[MSB]) & (res[MSB] != a[MSB]);
            end
            4'd3: begin
                res   = sum[MSB:0];
                res_c = sum[WIDTH];
                res_v = (a[MSB] == b[MSB]) & (res[MSB] != a[MSB]);
            end
            4'd4: res = a ^ b;
            4'd5: res = a | b;
            4'd6: res = a & b;
            4'd7: res = '1;
            4'd8: begin
                res   = shl[MSB:0];
                res_c = shl[WIDTH];
            end
            4'd9: begin
                res   = shr_l[WIDTH:1];
                res_c = shr_l[0];
            end
            4'd10: begin
                res   = shr_a[WIDTH:1];
                res_c = shr_a[0];
            end
            4'd11: res = '0;
            4'd12: res = {{(WIDTH-1){1'b0}}, diff_ab[WIDTH]};
            default: res_e = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z          <= '0;
            flag_zero  <= 1'b0;
            flag_neg   <= 1'b0;
            flag_carry <= 1'b0;
            flag_ovf   <= 1'b0;
            flag_err   <= 1'b0;
            mul_a      <= '0;
            mul_b      <= '0;
            acc        <= '0;
            mul_cnt    <= '0;
        end else begin
            if (accept && !start_mul) begin
                z          <= res;
                flag_zero  <= (res == '0);
                flag_neg   <= res[MSB];
                flag_carry <= res_c;
                flag_ovf   <= res_v;
                flag_err   <= res_e;
            end
            if (start_mul) begin
                mul_a   <= {{WIDTH{1'b0}}, a};
                mul_b   <= b;
                acc     <= '0;
                mul_cnt <= '0;
            end else if (state == BUSY) begin
                acc     <= acc_next;
                mul_a   <= mul_a << 1;
                mul_b   <= mul_b >> 1;
                mul_cnt <= mul_cnt + SHW'(1);
                // Final multiplier bit: publish low half, flag any upper-half bits.
                if (mul_last) begin
                    z          <= acc_next[MSB:0];
                    flag_zero  <= (acc_next[MSB:0] == '0);
                    flag_neg   <= acc_next[MSB];
                    flag_carry <= |acc_next[2*WIDTH-1:WIDTH];
                    flag_ovf   <= 1'b0;
                    flag_err   <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (WIDTH=8): expected results go into a queue at
// issue time and a monitor pops and compares each transferred result.
module tb_alu_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [3:0] op = '0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] z;
    logic       flag_zero, flag_neg, flag_carry, flag_ovf, flag_err;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q[$];
    logic [12:0] got_v;
    logic [12:0] exp_v;

    alu_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .out_valid(out_valid), .out_ready(out_ready),
        .z(z), .flag_zero(flag_zero), .flag_neg(flag_neg),
        .flag_carry(flag_carry), .flag_ovf(flag_ovf), .flag_err(flag_err)
    );

    always #5 clk = ~clk;

    assign got_v = {z, flag_zero, flag_neg, flag_carry, flag_ovf, flag_err};

    function automatic logic [12:0] pack(input logic [7:0] zz, input logic c,
                                         input logic v, input logic e);
        return {zz, (zz == 8'h00), zz[7], c, v, e};
    endfunction

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    // Monitor: every transferred result must match the head of the queue.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_result: got %h with nothing expected", got_v);
            end else begin
                exp_v = exp_q.pop_front();
                if (got_v !== exp_v) begin
                    errors++;
                    $display("FAIL result: got z=%h flags(zncve)=%b expected z=%h flags=%b",
                             got_v[12:5], got_v[4:0], exp_v[12:5], exp_v[4:0]);
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the accepting edge with inputs scrambled.
    task automatic send(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y);
        int n;
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        n = 0;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: in_ready never rose for op %0d", o);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        op = 4'($urandom_range(0, 15));
    endtask

    task automatic wait_valid(input string nm, input int lat);
        int n;
        n = 1;
        while (!out_valid && n <= 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({nm, "_latency"}, n, lat);
    endtask

    task automatic do_op(input string nm, input logic [3:0] o, input logic [7:0] x,
                         input logic [7:0] y, input logic [12:0] e, input int lat);
        exp_q.push_back(e);
        send(o, x, y);
        wait_valid(nm, lat);
        @(posedge clk); #1;
    endtask

    initial begin
        int stale;
        int n;
        #1;
        check("reset_z", z, 8'h00);
        check("reset_flags", {flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}, 5'b0);
        check("reset_out_valid", out_valid, 1'b0);
        check("reset_in_ready", in_ready, 1'b1);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;

        do_op("add_ovf", 4'd3, 8'h7F, 8'h01, pack(8'h80, 1'b0, 1'b1, 1'b0), 1);

        // Reset in the third BUSY cycle of a multiply; no result may surface.
        send(4'd11, 8'd13, 8'd11);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midmul_rst_z", z, 8'h00);
        check("midmul_rst_flags", {flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}, 5'b0);
        check("midmul_rst_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        check("post_rst_in_ready", in_ready, 1'b1);
        stale = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (out_valid) stale = 1;
        end
        check("no_stale_result", stale, 0);

        do_op("sub_a_b",   4'd2,  8'h05, 8'h07, pack(8'hFE, 1'b1, 1'b0, 1'b0), 1);
        do_op("sub_b_a",   4'd1,  8'h05, 8'h07, pack(8'h02, 1'b0, 1'b0, 1'b0), 1);
        do_op("sub_ovf",   4'd2,  8'h80, 8'h01, pack(8'h7F, 1'b0, 1'b1, 1'b0), 1);
        do_op("add_wrap",  4'd3,  8'hFF, 8'h01, pack(8'h00, 1'b1, 1'b0, 1'b0), 1);
        do_op("sra",       4'd10, 8'h90, 8'h05, pack(8'hFC, 1'b1, 1'b0, 1'b0), 1);
        do_op("shl_mask",  4'd8,  8'h81, 8'h09, pack(8'h02, 1'b1, 1'b0, 1'b0), 1);
        do_op("srl_zero",  4'd9,  8'h81, 8'h00, pack(8'h81, 1'b0, 1'b0, 1'b0), 1);
        do_op("srl_3",     4'd9,  8'h8C, 8'h03, pack(8'h11, 1'b1, 1'b0, 1'b0), 1);
        do_op("lt_true",   4'd12, 8'h03, 8'h09, pack(8'h01, 1'b0, 1'b0, 1'b0), 1);
        do_op("lt_false",  4'd12, 8'h09, 8'h03, pack(8'h00, 1'b0, 1'b0, 1'b0), 1);
        do_op("preset",    4'd7,  8'h12, 8'h34, pack(8'hFF, 1'b0, 1'b0, 1'b0), 1);
        do_op("clear",     4'd0,  8'h55, 8'hAA, pack(8'h00, 1'b0, 1'b0, 1'b0), 1);
        do_op("and",       4'd6,  8'hF0, 8'h3C, pack(8'h30, 1'b0, 1'b0, 1'b0), 1);
        do_op("mul_small", 4'd11, 8'd13, 8'd11, pack(8'h8F, 1'b0, 1'b0, 1'b0), 9);
        do_op("mul_big",   4'd11, 8'd200, 8'd3, pack(8'h58, 1'b1, 1'b0, 1'b0), 9);
        do_op("reserved",  4'd14, 8'h12, 8'h34, pack(8'h00, 1'b0, 1'b0, 1'b1), 1);

        // Backpressure: result must hold, then a pending op follows with no bubble.
        out_ready = 1'b0;
        exp_q.push_back(pack(8'h3F, 1'b0, 1'b0, 1'b0));
        send(4'd5, 8'h0F, 8'h30);
        wait_valid("or_hold", 1);
        for (int i = 0; i < 5; i++) begin
            check("hold_z", z, 8'h3F);
            check("hold_flags", {flag_zero, flag_neg, flag_carry, flag_ovf, flag_err}, 5'b0);
            check("hold_in_ready", in_ready, 1'b0);
            check("hold_out_valid", out_valid, 1'b1);
            @(posedge clk); #1;
        end
        in_valid = 1'b1;
        op = 4'd4;
        a = 8'hF0;
        b = 8'h3C;
        exp_q.push_back(pack(8'hCC, 1'b0, 1'b0, 1'b0));
        out_ready = 1'b1;
        #1;
        check("release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("no_bubble_valid", out_valid, 1'b1);
        check("no_bubble_z", z, 8'hCC);
        @(posedge clk); #1;

        n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule
